alu_lane_sequencer: RTL and testbench
=====================================

// Module: alu_lane_sequencer
// PURPOSE
//  Time-multiplexes one shared scalar ALU (add/sub/mul/div/move) across the LANES elements of a
//  vector operation. Accepts one vector op per valid/ready handshake and drives the ALU one lane
//  per cycle. Registers each lane result and flag set, then presents the full result vector with
//  aggregated flags. Sits in Execute between the vector register read stage and writeback.
//  The ALU instance lives in the parent; it is purely combinational.
// PARAMETERS
//  WIDTH   19  element / ALU datapath width in bits
//  LANES   4   vector elements per op (>=2)
//  IDX_W   $clog2(LANES)  lane index width (derived, not overridden)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous, active-high reset
//  in_valid     in   1            vector op offered
//  in_ready     out  1            sequencer can accept (registered; high only in IDLE)
//  in_sel       in   4            ALU opcode, forwarded unchanged to alu_sel
//  in_mask      in   LANES        lane enable; bit i enables element i
//  in_a, in_b   in   LANES*WIDTH  operand vectors; element i = bits [i*WIDTH +: WIDTH]
//  alu_a, alu_b out  WIDTH        operands of the current lane to the ALU
//  alu_sel      out  4            latched opcode to the ALU
//  alu_out      in   WIDTH        ALU result (same cycle)
//  alu_n/z/v/c  in   1 each       ALU flags (same cycle)
//  out_valid    out  1            result vector valid
//  out_ready    in   1            consumer accepts result
//  out_res      out  LANES*WIDTH  result vector
//  out_nmask    out  LANES        per-lane N flag (0 for disabled lanes)
//  out_zmask    out  LANES        per-lane Z flag (0 for disabled lanes)
//  out_any_v    out  1            OR of V over enabled lanes
//  out_any_c    out  1            OR of C over enabled lanes
//  busy         out  1            high in RUN or DONE
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, busy=0. out_res, the masks, the any flags, alu_* and
//   all internal latches = 0. State = IDLE, lane index = 0.
//  FSM IDLE -> RUN when in_valid & in_ready. On that edge latch in_sel, in_mask, in_a and in_b;
//   clear the result and flag registers; set idx=0.
//  RUN: one lane per cycle. alu_a/alu_b = latched element[idx]; alu_sel = latched sel.
//   Enabled lane: at the clock edge store alu_out into res[idx], alu_n into nmask[idx] and alu_z
//    into zmask[idx]; OR alu_v into any_v and alu_c into any_c.
//   Disabled lane: res[idx] = element A[idx]. Its mask bits stay 0; it adds nothing to any_v/c.
//    It still takes one cycle, so latency is fixed.
//   idx==LANES-1 -> DONE. There is no early exit, including when the mask is all zero.
//  DONE: out_valid=1. Outputs stay stable until out_ready. On out_valid & out_ready -> IDLE.
//   in_ready rises the next cycle; there is no same-cycle re-accept.
//  Latency: in_valid accepted at edge T -> out_valid high after edge T+LANES.
//   Throughput: one op per LANES+2 cycles with out_ready tied high.
//  Outside IDLE: in_ready=0 and in_valid is ignored. Operands are not sampled mid-op.
//  In IDLE and DONE, alu_a/alu_b/alu_sel hold their last values; nothing is captured.
//  Opcodes: no decode. Unknown codes pass through; the ALU default (pass A) then applies.
//   Divide-by-zero results and flags are captured exactly as the ALU returns them.
//  Arithmetic: all WIDTH-bit, no widening. Wrap, overflow and sign come from the ALU.
//  Reset mid-RUN or mid-DONE: immediate return to reset values; the op is discarded.
// STRUCTURE
//  Shared package alu_pkg:
//   ALU opcode localparams: OP_MOV=4'b0010, OP_ADD=4'b0100, OP_SUB=4'b0101,
//    OP_DIV=4'b0110, OP_MUL=4'b0111, OP_PASSA=4'b1111.
//   typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t.
//  Single module, no sub-module. Element select is an indexed part-select on idx.
// TESTING (WIDTH=19, LANES=4)
//  1. ADD, mask 1111, A={1,2,3,4}, B={10,20,30,40}
//     -> res={11,22,33,44}, zmask=0, any_v=0, out_valid 4 cycles after accept.
//  2. SUB, A={5,7,0,9}, B={5,8,0,1}
//     -> res={0,0x7FFFF,0,8}, zmask=0101, nmask=0010.
//  3. ADD, lane2 A=0x3FFFF B=1, mask 0100
//     -> res[2]=0x40000, nmask=0100, any_v=1. Lanes 0,1,3 = their A values.
//  4. out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0.
//     A second in_valid during this time is not accepted. Release -> in_ready=1 one cycle later.
//  5. rst pulsed while idx=2 -> all outputs at reset values.
//     The next op (MUL {3,3,3,3}x{2,2,2,2}) -> {6,6,6,6}.
//  6. Mask 0000 with DIV -> still 4 cycles; res=A, all masks/flags 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the shared scalar ALU and the lane sequencer that
//   drives it: opcode encodings and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_MOV   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_DIV   = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b0111;
  localparam logic [3:0] OP_PASSA = 4'b1111;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/alu_lane_sequencer.sv
// alu_lane_sequencer
//   Time-multiplexes one shared combinational scalar ALU across the LANES
//   elements of a vector op. One op is accepted per handshake in IDLE, the
//   ALU is driven one lane per cycle in RUN, and the registered result vector
//   plus aggregated flags are held in DONE until the consumer takes them.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        op handshake (in_ready high only in IDLE)
//   in_sel, in_mask          opcode (forwarded, not decoded), lane enables
//   in_a, in_b               operand vectors, element i at [i*WIDTH +: WIDTH]
//   alu_a, alu_b, alu_sel    current lane operands / opcode to the ALU
//   alu_out, alu_n/z/v/c     same-cycle ALU result and flags
//   out_valid/out_ready      result handshake
//   out_res                  result vector
//   out_nmask, out_zmask     per-lane N / Z flags (0 for disabled lanes)
//   out_any_v, out_any_c     OR of V / C over enabled lanes
//   busy                     high in RUN or DONE
module alu_lane_sequencer
  import alu_pkg::*;
#(
  parameter  int WIDTH = 19,
  parameter  int LANES = 4,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_sel,
  input  logic [LANES-1:0]       in_mask,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_n,
  input  logic                   alu_z,
  input  logic                   alu_v,
  input  logic                   alu_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_res,
  output logic [LANES-1:0]       out_nmask,
  output logic [LANES-1:0]       out_zmask,
  output logic                   out_any_v,
  output logic                   out_any_c,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [3:0]             r_sel;
  logic [LANES-1:0]       r_mask;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic [LANES*WIDTH-1:0] r_res;
  logic [LANES-1:0]       r_nmask;
  logic [LANES-1:0]       r_zmask;
  logic                   r_any_v;
  logic                   r_any_c;
  logic                   w_accept;
  logic [WIDTH-1:0]       w_a_elem;
  logic [WIDTH-1:0]       w_b_elem;

  assign w_accept = in_valid && (r_state == SEQ_IDLE);

  // The ALU operands are a pure select of the latched vectors. r_idx parks on
  // the last lane after RUN and the latches only change on accept, so the
  // ALU inputs naturally hold their last values through DONE and IDLE.
  assign w_a_elem = r_a[r_idx*WIDTH +: WIDTH];
  assign w_b_elem = r_b[r_idx*WIDTH +: WIDTH];

  assign alu_a     = w_a_elem;
  assign alu_b     = w_b_elem;
  assign alu_sel   = r_sel;
  assign in_ready  = (r_state == SEQ_IDLE);
  assign out_valid = (r_state == SEQ_DONE);
  assign busy      = (r_state != SEQ_IDLE);
  assign out_res   = r_res;
  assign out_nmask = r_nmask;
  assign out_zmask = r_zmask;
  assign out_any_v = r_any_v;
  assign out_any_c = r_any_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // No early exit: every op walks all lanes so latency is fixed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEQ_IDLE: if (w_accept)            w_state_nxt = SEQ_RUN;
      SEQ_RUN:  if (r_idx == LAST_IDX)   w_state_nxt = SEQ_DONE;
      SEQ_DONE: if (out_ready)           w_state_nxt = SEQ_IDLE;
      default:                           w_state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_sel   <= '0;
      r_mask  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_nmask <= '0;
      r_zmask <= '0;
      r_any_v <= 1'b0;
      r_any_c <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_accept) begin
            r_sel   <= in_sel;
            r_mask  <= in_mask;
            r_a     <= in_a;
            r_b     <= in_b;
            r_res   <= '0;
            r_nmask <= '0;
            r_zmask <= '0;
            r_any_v <= 1'b0;
            r_any_c <= 1'b0;
            r_idx   <= '0;
          end
        end
        SEQ_RUN: begin
          if (r_mask[r_idx]) begin
            r_res[r_idx*WIDTH +: WIDTH] <= alu_out;
            r_nmask[r_idx]              <= alu_n;
            r_zmask[r_idx]              <= alu_z;
            r_any_v                     <= r_any_v | alu_v;
            r_any_c                     <= r_any_c | alu_c;
          end else begin
            // Disabled lanes pass their A element through untouched.
            r_res[r_idx*WIDTH +: WIDTH] <= w_a_elem;
          end
          if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_lane_sequencer.sv
module tb_alu_lane_sequencer;
  import alu_pkg::*;

  localparam int W  = 19;
  localparam int LN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_sel;
  logic [LN-1:0]   in_mask;
  logic [LN*W-1:0] in_a, in_b;
  logic [W-1:0]    alu_a, alu_b;
  logic [3:0]      alu_sel;
  logic [W-1:0]    alu_out;
  logic            alu_n, alu_z, alu_v, alu_c;
  logic            out_valid;
  logic            out_ready;
  logic [LN*W-1:0] out_res;
  logic [LN-1:0]   out_nmask, out_zmask;
  logic            out_any_v, out_any_c;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_lane_sequencer #(.WIDTH(W), .LANES(LN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_mask(in_mask), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_nmask(out_nmask), .out_zmask(out_zmask),
    .out_any_v(out_any_v), .out_any_c(out_any_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scalar ALU: returns {result, n, z, v, c}.
  function automatic logic [W+3:0] alu_fn(input logic [3:0] sel,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         v, c;
    v = 1'b0;
    c = 1'b0;
    case (sel)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[W-1:0];
        c = t[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[W-1:0];
        c = t[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_MUL: r = a * b;
      OP_DIV: begin
        r = (b == '0) ? '1 : a / b;
        v = (b == '0);
      end
      OP_MOV:  r = b;
      default: r = a;
    endcase
    return {r, r[W-1], (r == '0), v, c};
  endfunction

  always_comb {alu_out, alu_n, alu_z, alu_v, alu_c} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic logic [LN*W-1:0] pack4(input int e0, input int e1,
                                            input int e2, input int e3);
    logic [LN*W-1:0] v;
    v[0*W +: W] = W'(e0);
    v[1*W +: W] = W'(e1);
    v[2*W +: W] = W'(e2);
    v[3*W +: W] = W'(e3);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-vector reference: enabled lanes take the ALU result and flags,
  // disabled lanes pass A and contribute nothing.
  task automatic model_op(input logic [3:0] sel, input logic [LN-1:0] mask,
                          input logic [LN*W-1:0] a, input logic [LN*W-1:0] b,
                          output logic [LN*W-1:0] res, output logic [LN-1:0] nm,
                          output logic [LN-1:0] zm, output logic av, output logic ac);
    logic [W+3:0] f;
    res = '0; nm = '0; zm = '0; av = 1'b0; ac = 1'b0;
    for (int i = 0; i < LN; i++) begin
      if (mask[i]) begin
        f = alu_fn(sel, a[i*W +: W], b[i*W +: W]);
        res[i*W +: W] = f[W+3:4];
        nm[i] = f[3];
        zm[i] = f[2];
        av |= f[1];
        ac |= f[0];
      end else begin
        res[i*W +: W] = a[i*W +: W];
      end
    end
  endtask

  task automatic run_op(input logic [3:0] sel, input logic [LN-1:0] mask,
                        input logic [LN*W-1:0] a, input logic [LN*W-1:0] b,
                        input int hold);
    logic [LN*W-1:0] e_res;
    logic [LN-1:0]   e_nm, e_zm;
    logic            e_av, e_ac;
    int              cyc;
    model_op(sel, mask, a, b, e_res, e_nm, e_zm, e_av, e_ac);
    in_sel = sel; in_mask = mask; in_a = a; in_b = b;
    out_ready = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_run", busy, 1'b1);
    check("alu_sel_run", alu_sel, sel);
    check("alu_a_lane0", alu_a, a[W-1:0]);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, LN);
    check("res", out_res, e_res);
    check("nmask", out_nmask, e_nm);
    check("zmask", out_zmask, e_zm);
    check("any_v", out_any_v, e_av);
    check("any_c", out_any_c, e_ac);
    check("ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = ~a; in_b = ~b; in_sel = ~sel; in_mask = ~mask;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_res", out_res, e_res);
      check("hold_flags", {out_nmask, out_zmask, out_any_v, out_any_c},
            {e_nm, e_zm, e_av, e_ac});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
    check("release_busy", busy, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_res"}, out_res, '0);
    check({tag, "_masks"}, {out_nmask, out_zmask, out_any_v, out_any_c}, '0);
    check({tag, "_alu"}, {alu_a, alu_b, alu_sel}, '0);
  endtask

  initial begin
    logic [3:0]    ops [7];
    logic [3:0]    sel;
    logic [LN*W-1:0] a, b;
    int            cyc;
    ops = '{OP_MOV, OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_PASSA, 4'b0000};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = '0; in_mask = '0; in_a = '0; in_b = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADD, all lanes.
    run_op(OP_ADD, 4'b1111, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 0);
    check("t1_res_const", out_res, pack4(11, 22, 33, 44));

    // SUB with zero and negative results.
    run_op(OP_SUB, 4'b1111, pack4(5, 7, 0, 9), pack4(5, 8, 0, 1), 0);
    check("t2_res_const", out_res, pack4(0, 'h7FFFF, 0, 8));
    check("t2_masks_const", {out_zmask, out_nmask}, {4'b0101, 4'b0010});

    // Signed overflow on the only enabled lane.
    run_op(OP_ADD, 4'b0100, pack4(5, 6, 'h3FFFF, 8), pack4(1, 1, 1, 1), 0);
    check("t3_res_const", out_res, pack4(5, 6, 'h40000, 8));
    check("t3_flags_const", {out_nmask, out_any_v}, {4'b0100, 1'b1});

    // Consumer stalls in DONE with a competing offer.
    run_op(OP_MUL, 4'b1011, pack4(2, 3, 4, 5), pack4(7, 7, 7, 7), 10);

    // Reset while lane 2 is in flight.
    in_sel = OP_ADD; in_mask = 4'b1111;
    in_a = pack4(9, 9, 9, 9); in_b = pack4(1, 1, 1, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 check_reset_state("midrun_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("after_rst");
    run_op(OP_MUL, 4'b1111, pack4(3, 3, 3, 3), pack4(2, 2, 2, 2), 0);
    check("t5_res_const", out_res, pack4(6, 6, 6, 6));

    // All lanes disabled still walks every lane.
    run_op(OP_DIV, 4'b0000, pack4(100, 200, 300, 400), pack4(0, 3, 0, 5), 0);
    check("t6_res_const", out_res, pack4(100, 200, 300, 400));

    // Divide by zero on enabled lanes.
    run_op(OP_DIV, 4'b1111, pack4(100, 200, 300, 400), pack4(0, 3, 0, 5), 1);

    // Randomized ops, including undefined opcodes.
    for (int k = 0; k < 24; k++) begin
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : ops[$urandom_range(0, 6)];
      for (int i = 0; i < LN; i++) begin
        a[i*W +: W] = W'($urandom);
        b[i*W +: W] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      end
      run_op(sel, 4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3));
    end

    // Back-to-back throughput with out_ready tied high.
    out_ready = 1'b1;
    in_sel = OP_ADD; in_mask = 4'b1111;
    in_a = pack4(1, 1, 1, 1); in_b = pack4(1, 1, 1, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check("throughput", cyc + 1, LN + 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
